// File: rtl/fwd_pkg.sv
// Shared sizing defaults and the in-flight producer entry layout for the
// forwarding scoreboard.
package fwd_pkg;

    localparam int FWD_REG_ADDR_W = 5;
    localparam int FWD_DEPTH      = 3;
    localparam int FWD_SEL_W      = $clog2(FWD_DEPTH + 1);

    // One tracked producer at default sizing: cnt is the number of further
    // stages it must travel before its result can be forwarded.
    typedef struct packed {
        logic                      valid;
        logic                      rw;
        logic [FWD_REG_ADDR_W-1:0] rd;
        logic [FWD_SEL_W-1:0]      cnt;
    } fwd_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Priority lookup of one source operand against all in-flight producers.
// The youngest matching producer decides the outcome: forward from its stage
// if its result is ready, otherwise report a hazard and select the regfile.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = FWD_REG_ADDR_W,
    parameter int DEPTH      = FWD_DEPTH,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                             src_en_i,
    input  logic [REG_ADDR_W-1:0]            src_addr_i,
    input  logic [DEPTH-1:0]                 ent_valid_i,
    input  logic [DEPTH-1:0]                 ent_rw_i,
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd_i,
    input  logic [DEPTH-1:0][SEL_W-1:0]      ent_cnt_i,
    output logic [SEL_W-1:0]                 sel_o,
    output logic                             hazard_o
);

    logic [DEPTH-1:0] hit;

    // Per-stage match; r0 is never a real producer.
    always_comb begin
        hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit[k] = src_en_i && ent_valid_i[k] && ent_rw_i[k]
                     && (ent_rd_i[k] != '0) && (ent_rd_i[k] == src_addr_i);
        end
    end

    // Scan oldest to youngest so the youngest hit has the final word.
    always_comb begin
        sel_o    = '0;
        hazard_o = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                if (ent_cnt_i[k] == '0) begin
                    sel_o    = SEL_W'(k + 1);
                    hazard_o = 1'b0;
                end else begin
                    sel_o    = '0;
                    hazard_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Operand forwarding scoreboard: tracks the producers in the stages behind the
// consumer, picks a forwarding source per operand and stalls the consumer when
// the youngest producer of an operand is not yet ready.
module forward_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = FWD_REG_ADDR_W,
    parameter int DEPTH      = FWD_DEPTH,
    parameter int NUM_SRC    = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          issue_valid_i,
    input  logic                          issue_rw_i,
    input  logic [REG_ADDR_W-1:0]         issue_rd_i,
    input  logic [SEL_W-1:0]              issue_lat_i,
    input  logic [NUM_SRC-1:0]            src_en_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_i,
    input  logic                          flush_i,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o,
    output logic                          stall_o,
    output logic [15:0]                   stall_cnt_o
);

    // Same layout as fwd_entry_t, resized to this instance's parameters.
    typedef struct packed {
        logic                  valid;
        logic                  rw;
        logic [REG_ADDR_W-1:0] rd;
        logic [SEL_W-1:0]      cnt;
    } entry_t;

    // A result can never need more extra stages than remain in the tracker.
    localparam logic [SEL_W-1:0] MAX_CNT = SEL_W'(DEPTH - 1);

    entry_t [DEPTH-1:0]            ent_q;
    entry_t [DEPTH-1:0]            ent_d;
    logic   [15:0]                 stall_cnt_q;
    logic   [15:0]                 stall_cnt_d;

    logic   [DEPTH-1:0]            ent_valid;
    logic   [DEPTH-1:0]            ent_rw;
    logic   [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
    logic   [DEPTH-1:0][SEL_W-1:0] ent_cnt;
    logic   [NUM_SRC-1:0]          src_hazard;
    logic                          issue_fire;
    logic   [SEL_W-1:0]            issue_cnt;

    // Split the entry array into per-field vectors for the lookup units.
    always_comb begin
        ent_valid = '0;
        ent_rw    = '0;
        ent_rd    = '0;
        ent_cnt   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ent_valid[k] = ent_q[k].valid;
            ent_rw[k]    = ent_q[k].rw;
            ent_rd[k]    = ent_q[k].rd;
            ent_cnt[k]   = ent_q[k].cnt;
        end
    end

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_match
        fwd_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .SEL_W      (SEL_W)
        ) u_match (
            .src_en_i    (src_en_i[j]),
            .src_addr_i  (src_addr_i[j*REG_ADDR_W +: REG_ADDR_W]),
            .ent_valid_i (ent_valid),
            .ent_rw_i    (ent_rw),
            .ent_rd_i    (ent_rd),
            .ent_cnt_i   (ent_cnt),
            .sel_o       (fwd_sel_o[j*SEL_W +: SEL_W]),
            .hazard_o    (src_hazard[j])
        );
    end

    assign stall_o     = (|src_hazard) && issue_valid_i && !flush_i;
    assign issue_fire  = issue_valid_i && !stall_o && !flush_i;
    assign issue_cnt   = (issue_lat_i > MAX_CNT) ? MAX_CNT : issue_lat_i;
    assign stall_cnt_o = stall_cnt_q;

    // Advance the tracker every cycle; stage 1 gets the issued instruction or
    // a bubble, and each older stage is one step closer to its result.
    always_comb begin
        ent_d       = '0;
        stall_cnt_d = stall_cnt_q;
        if (issue_fire) begin
            ent_d[0].valid = 1'b1;
            ent_d[0].rw    = issue_rw_i;
            ent_d[0].rd    = issue_rd_i;
            ent_d[0].cnt   = issue_cnt;
        end
        for (int k = 1; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k-1];
            if (ent_q[k-1].cnt != '0) begin
                ent_d[k].cnt = ent_q[k-1].cnt - SEL_W'(1);
            end
        end
        if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ent_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            ent_q       <= ent_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
